// File: rtl/fft16_bfly_engine.sv
// fft16_bfly_engine: in-place 16-point radix-2 FFT over a 16-entry register bank.
// Loads 16 complex samples, runs 4 MUL/ADD butterfly stages using addresses and
// twiddles from an external combinational LUT, then streams the bank out 0..15.
// Each stage scales by 1/2, so the frame result is scaled by 1/16.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 begin a frame (sampled in IDLE only)
//   in_valid/in_ready     sample input handshake, in_data = {re, im}
//   stage                 stage index to the LUT
//   lut_addr, lut_w       16 bank addresses (4b each), 8 twiddles {re, im} Q1.14
//   out_valid/out_ready   result output handshake, out_data = {re, im}
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse after the last result is accepted

// Complex multiply P = W * B, truncated to DW+1 bits per component after the
// TW_FRAC shift (|W| <= 1 keeps |P| within DW+1 bits).
module fft16_cmul #(
    parameter int DW      = 16,
    parameter int TW      = 16,
    parameter int TW_FRAC = 14
) (
    input  logic [2*DW-1:0]     b_i,
    input  logic [2*TW-1:0]     w_i,
    output logic [2*(DW+1)-1:0] p_o
);
    localparam int PW = DW + TW + 1;
    logic signed [PW-1:0] br, bi, wr, wi, pr, pi;

    // Sign-extend to the product width so the difference/sum cannot wrap.
    assign br = {{(TW+1){b_i[2*DW-1]}}, b_i[2*DW-1:DW]};
    assign bi = {{(TW+1){b_i[DW-1]}},   b_i[DW-1:0]};
    assign wr = {{(DW+1){w_i[2*TW-1]}}, w_i[2*TW-1:TW]};
    assign wi = {{(DW+1){w_i[TW-1]}},   w_i[TW-1:0]};

    assign pr = br * wr - bi * wi;
    assign pi = br * wi + bi * wr;

    // Bit slice == arithmetic shift right by TW_FRAC, truncated to DW+1 bits.
    assign p_o = {pr[DW+TW_FRAC:TW_FRAC], pi[DW+TW_FRAC:TW_FRAC]};
endmodule

module fft16_bfly_engine #(
    parameter int DW      = 16,
    parameter int TW      = 16,
    parameter int TW_FRAC = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   in_data,
    output logic [1:0]        stage,
    input  logic [63:0]       lut_addr,
    input  logic [16*TW-1:0]  lut_w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   out_data,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, LOAD, MUL, ADD, DRAIN} state_t;

    state_t                          state_q, state_d;
    logic [3:0]                      cnt_q, cnt_d;
    logic [1:0]                      stage_q, stage_d;
    logic                            done_q, done_d;
    logic [15:0][2*DW-1:0]           bank_q, bank_d;
    logic [7:0][2*DW-1:0]            a_q;
    logic [7:0][2*(DW+1)-1:0]        p_q, p_w;
    logic [63:0]                     addr_q;
    logic [7:0][2*DW-1:0]            sum_w, dif_w;

    for (genvar k = 0; k < 8; k++) begin : g_bf
        // MUL side: B operand read straight from the bank at the LUT address.
        fft16_cmul #(.DW(DW), .TW(TW), .TW_FRAC(TW_FRAC)) u_cmul (
            .b_i (bank_q[lut_addr[8*k+4 +: 4]]),
            .w_i (lut_w[2*TW*k +: 2*TW]),
            .p_o (p_w[k])
        );

        // ADD side: (A +/- P) >>> 1 in DW+2 bits, truncated back to DW.
        logic signed [DW+1:0] ar, ai, pr, pi, sr, si, dr, di;
        assign ar = {{2{a_q[k][2*DW-1]}}, a_q[k][2*DW-1:DW]};
        assign ai = {{2{a_q[k][DW-1]}},   a_q[k][DW-1:0]};
        assign pr = {p_q[k][2*DW+1], p_q[k][2*DW+1:DW+1]};
        assign pi = {p_q[k][DW],     p_q[k][DW:0]};
        assign sr = ar + pr;
        assign si = ai + pi;
        assign dr = ar - pr;
        assign di = ai - pi;
        assign sum_w[k] = {sr[DW:1], si[DW:1]};
        assign dif_w[k] = {dr[DW:1], di[DW:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        done_d  = 1'b0;
        bank_d  = bank_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = 4'd0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    bank_d[cnt_q] = in_data;
                    cnt_d         = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = MUL;
                        stage_d = 2'd0;
                    end
                end
            end
            MUL: state_d = ADD;
            ADD: begin
                for (int k = 0; k < 8; k++) begin
                    bank_d[addr_q[8*k   +: 4]] = sum_w[k];
                    bank_d[addr_q[8*k+4 +: 4]] = dif_w[k];
                end
                if (stage_q != 2'd3) begin
                    stage_d = stage_q + 2'd1;
                    state_d = MUL;
                end else begin
                    stage_d = 2'd0;
                    cnt_d   = 4'd0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            bank_q  <= '0;
            a_q     <= '0;
            p_q     <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            bank_q  <= bank_d;
            if (state_q == MUL) begin
                addr_q <= lut_addr;
                p_q    <= p_w;
                for (int k = 0; k < 8; k++) a_q[k] <= bank_q[lut_addr[8*k +: 4]];
            end
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign out_data  = (state_q == DRAIN) ? bank_q[cnt_q] : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign stage     = stage_q;
endmodule

// File: tb/tb_fft16_bfly_engine.sv
// Directed bench for fft16_bfly_engine. Models the stage LUT as an iterative
// radix-2 in-place pattern: stage s pairs (a, a+2^s) with twiddle
// exp(-j*2*pi*e/16), e = (a mod 2^s) * (8 >> s).
module tb_fft16_bfly_engine;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, busy, done;
    logic [31:0]  in_data = '0, out_data;
    logic [1:0]   stage;
    logic [63:0]  lut_addr;
    logic [255:0] lut_w;
    int           total = 0, bad = 0;

    always #5 clk = ~clk;

    fft16_bfly_engine #(.DW(16), .TW(16), .TW_FRAC(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .stage(stage), .lut_addr(lut_addr), .lut_w(lut_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    function automatic logic [31:0] tw(input int e);
        case (e)
            0:       tw = {16'sd16384,  16'sd0};
            1:       tw = {16'sd15137, -16'sd6270};
            2:       tw = {16'sd11585, -16'sd11585};
            3:       tw = {16'sd6270,  -16'sd15137};
            4:       tw = {16'sd0,     -16'sd16384};
            5:       tw = {-16'sd6270, -16'sd15137};
            6:       tw = {-16'sd11585, -16'sd11585};
            7:       tw = {-16'sd15137, -16'sd6270};
            default: tw = '0;
        endcase
    endfunction

    function automatic logic [3:0] bfa(input int s, input int m);
        int half;
        half = 1 << s;
        return 4'((m / half) * 2 * half + m % half);
    endfunction

    function automatic int bfe(input int s, input int m);
        int half;
        half = 1 << s;
        return (m % half) * (8 >> s);
    endfunction

    always_comb begin
        lut_addr = '0;
        lut_w    = '0;
        for (int m = 0; m < 8; m++) begin
            lut_addr[8*m   +: 4] = bfa(int'(stage), m);
            lut_addr[8*m+4 +: 4] = bfa(int'(stage), m) + 4'(1 << stage);
            lut_w[32*m +: 32]    = tw(bfe(int'(stage), m));
        end
    end

    function automatic logic [31:0] cx(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    typedef struct {
        string             nm;
        logic [15:0][31:0] din;
        logic [15:0][31:0] dexp;
    } vec_t;
    vec_t vt[4];

    // Start pulse then 16 beats; optional 3-cycle in_valid gap after beat gap_after.
    task automatic load_frame(input logic [15:0][31:0] din, input int gap_after, output int rdy_bad);
        rdy_bad = 0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = din[i];
            if (!in_ready) rdy_bad++;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = 32'hdead_beef;
            if (i == gap_after) begin
                repeat (3) begin
                    if (!in_ready) rdy_bad++;
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic run_frame(input string nm, input logic [15:0][31:0] din, input logic [15:0][31:0] dexp,
                             input int gap_after, input bit bp, input bit poke);
        logic [15:0][31:0] got;
        logic [31:0]       held;
        logic [3:0]        pat;
        bit                was_stall;
        int rdy_bad, lat, busy_bad, n, stall_bad, done_early, cyc;
        pat = 4'b1001;
        got = '0;
        load_frame(din, gap_after, rdy_bad);
        chk({nm, "_in_ready_load"}, 32'(rdy_bad), 32'd0);
        chk({nm, "_in_ready_after"}, 32'(in_ready), 32'd0);
        // Latency counted in clock edges from the edge accepting beat 15.
        lat = 0; busy_bad = 0;
        start = poke;
        while (!out_valid && lat < 40) begin
            if (!busy) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd8);
        chk({nm, "_busy_compute"}, 32'(busy_bad), 32'd0);
        n = 0; stall_bad = 0; done_early = 0; cyc = 0;
        while (n < 16 && cyc < 200) begin
            start     = poke && (n < 8);
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            if (done) done_early++;
            if (!busy) busy_bad++;
            was_stall = out_valid && !out_ready;
            held      = out_data;
            if (out_valid && out_ready) begin
                got[n] = out_data;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
            if (was_stall && (out_data !== held || !out_valid)) stall_bad++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        chk({nm, "_beats"}, 32'(n), 32'd16);
        chk({nm, "_stall_stable"}, 32'(stall_bad), 32'd0);
        chk({nm, "_done_early"}, 32'(done_early), 32'd0);
        chk({nm, "_busy_drain"}, 32'(busy_bad), 32'd0);
        chk({nm, "_done_pulse"}, 32'(done), 32'd1);
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_done_clear"}, 32'(done), 32'd0);
        chk({nm, "_idle_valid"}, 32'(out_valid), 32'd0);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_out%0d", nm, i), got[i], dexp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int rb, vbad;
        for (int i = 0; i < 16; i++) begin
            vt[0].din[i] = (i == 0) ? cx(1000, 0) : '0;  vt[0].dexp[i] = cx(62, 0);
            vt[1].din[i] = cx(1600, 0);                  vt[1].dexp[i] = (i == 0) ? cx(1600, 0) : '0;
            vt[2].din[i] = (i == 0) ? cx(-1000, 0) : '0; vt[2].dexp[i] = cx(-63, 0);
            vt[3].din[i] = (i == 0) ? cx(0, 1000) : '0;  vt[3].dexp[i] = cx(0, 62);
        end
        vt[0].nm = "impulse"; vt[1].nm = "dc"; vt[2].nm = "neg_impulse"; vt[3].nm = "imag_impulse";

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stage", 32'(stage), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // in_valid while idle must be refused and must not start anything.
        in_valid = 1'b1; in_data = cx(777, 777); vbad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (in_ready || busy) vbad++;
        end
        in_valid = 1'b0;
        chk("idle_in_valid", 32'(vbad), 32'd0);

        for (int v = 0; v < 4; v++) run_frame(vt[v].nm, vt[v].din, vt[v].dexp, -1, 1'b0, 1'b0);

        run_frame("backpressure", vt[0].din, vt[0].dexp, -1, 1'b1, 1'b0);
        run_frame("gap", vt[1].din, vt[1].dexp, 5, 1'b0, 1'b0);
        run_frame("start_poke", vt[0].din, vt[0].dexp, -1, 1'b0, 1'b1);

        // Reset during stage 2 ADD: edges after beat 15 run MUL0,ADD0,MUL1,ADD1,MUL2,ADD2.
        load_frame(vt[1].din, -1, rb);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_stage2", 32'(stage), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_stage", 32'(stage), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vbad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid || busy || done) vbad++;
        end
        chk("post_rst_quiet", 32'(vbad), 32'd0);
        run_frame("post_rst_dc", vt[1].din, vt[1].dexp, -1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
